// File: rtl/load_store_controller.sv
// rtl/load_store_controller.sv - data-memory load/store sequencer with strobes, extension and timeout
module load_store_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_memory,
  input  logic        store_memory,
  input  logic [5:0]  load_memory_size,
  input  logic        load_memory_sign_extension,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic        reg_we_out,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMER_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t r_state, w_next;

  logic                   r_we;      // latched access is a store
  logic                   r_sign;
  logic [1:0]             r_size;
  logic [31:0]            r_addr;
  logic [31:0]            r_sdata;
  logic [31:0]            r_rdata;
  logic [4:0]             r_rd;
  logic                   r_fault;
  logic [1:0]             r_cause;
  logic [TIMER_WIDTH-1:0] r_timer;

  logic        w_accept;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_timeout;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  // Request decode: anything that is not 8 or 16 is handled as a full word.
  always_comb begin
    w_accept = (r_state == S_IDLE) && start && (load_memory || store_memory);
    if (load_memory_size == 6'd8)       w_size = SZ_B;
    else if (load_memory_size == 6'd16) w_size = SZ_H;
    else                                w_size = SZ_W;
    w_misaligned = ((w_size == SZ_H) && address[0]) ||
                   ((w_size == SZ_W) && (address[1:0] != 2'b00));
    w_timeout = TIMEOUT_EN && (r_timer == TIMER_LAST);
  end

  // Store lane replication/strobes and load alignment/extension from latched request.
  always_comb begin
    w_shift = r_rdata >> {r_addr[1:0], 3'b000};
    case (r_size)
      SZ_B: begin
        w_wdata = {4{r_sdata[7:0]}};
        w_wstrb = 4'b0001 << r_addr[1:0];
        w_load  = {{24{r_sign & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_H: begin
        w_wdata = {2{r_sdata[15:0]}};
        w_wstrb = 4'b0011 << r_addr[1:0];
        w_load  = {{16{r_sign & w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        w_wdata = r_sdata;
        w_wstrb = 4'b1111;
        w_load  = r_rdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a misaligned access skips the bus and reports directly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_misaligned ? S_RESP : S_REQ;
      S_REQ:  if (mem_ready || w_timeout) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latching, read capture, timeout tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_size  <= SZ_B;
      r_addr  <= '0;
      r_sdata <= '0;
      r_rdata <= '0;
      r_rd    <= '0;
      r_fault <= 1'b0;
      r_cause <= 2'b00;
      r_timer <= '0;
    end else if (w_accept) begin
      r_we    <= store_memory;
      r_sign  <= load_memory_sign_extension;
      r_size  <= w_size;
      r_addr  <= address;
      r_sdata <= store_data;
      r_rd    <= rd_in;
      r_fault <= w_misaligned;
      r_cause <= w_misaligned ? 2'b01 : 2'b00;
      r_timer <= '0;
    end else if (r_state == S_REQ) begin
      if (mem_ready) begin
        r_rdata <= mem_rdata;
      end else if (w_timeout) begin
        r_fault <= 1'b1;
        r_cause <= 2'b10;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Outputs: bus signals only in REQ, result signals only in RESP.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    load_data   = '0;
    rd_out      = '0;
    reg_we_out  = 1'b0;
    fault       = 1'b0;
    fault_cause = 2'b00;
    case (r_state)
      S_REQ: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_wdata = r_we ? w_wdata : 32'd0;
        mem_wstrb = r_we ? w_wstrb : 4'b0000;
        busy      = 1'b1;
      end
      S_RESP: begin
        busy        = 1'b1;
        done        = 1'b1;
        rd_out      = r_rd;
        fault       = r_fault;
        fault_cause = r_cause;
        reg_we_out  = !r_we && !r_fault;
        load_data   = (!r_we && !r_fault) ? w_load : 32'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_controller.sv
// tb/tb_load_store_controller.sv - randomized self-checking bench for load_store_controller
module tb_load_store_controller;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_memory;
  logic        store_memory;
  logic [5:0]  load_memory_size;
  logic        load_memory_sign_extension;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [4:0]  rd_out;
  logic        reg_we_out;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_vec = 0;
  int n_err = 0;

  load_store_controller #(.TIMEOUT_CYCLES(TMO), .TIMER_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_memory(load_memory), .store_memory(store_memory),
    .load_memory_size(load_memory_size),
    .load_memory_sign_extension(load_memory_sign_extension),
    .address(address), .store_data(store_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .load_data(load_data), .rd_out(rd_out),
    .reg_we_out(reg_we_out), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_bytes(input logic [5:0] sz);
    if (sz == 6'd8) return 1;
    if (sz == 6'd16) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input int nb, input bit sg, input int o,
                                           input logic [31:0] rdat);
    logic [31:0] w;
    w = rdat >> (8 * o);
    if (nb == 1) begin
      w = w & 32'h0000_00FF;
      if (sg && w >= 32'h80) w = w | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      w = w & 32'h0000_FFFF;
      if (sg && w >= 32'h8000) w = w | 32'hFFFF_0000;
    end
    return w;
  endfunction

  task automatic scramble_inputs(input bit rnd_start);
    start            = rnd_start ? 1'($urandom) : 1'b0;
    load_memory      = 1'($urandom);
    store_memory     = 1'($urandom);
    load_memory_size = 6'($urandom);
    load_memory_sign_extension = 1'($urandom);
    address          = $urandom;
    store_data       = $urandom;
    rd_in            = 5'($urandom);
  endtask

  // dly: index of the REQ cycle that sees mem_ready; >= TMO means never.
  task automatic do_access(input bit st, input bit ld, input logic [5:0] sz, input bit sg,
                           input logic [31:0] ad, input logic [31:0] sd, input logic [4:0] rd,
                           input int dly, input logic [31:0] rdat, input bit rnd_start);
    int nb, o, ncyc;
    bit is_store, mis, tmo;
    logic [31:0] exp_wd;
    logic [3:0]  exp_ws;
    nb = size_bytes(sz);
    o = int'(ad[1:0]);
    is_store = st;
    mis = (int'(ad % 32'(nb)) != 0);
    tmo = (dly >= TMO);
    ncyc = tmo ? TMO : dly + 1;
    if (nb == 1)      exp_wd = 32'(sd[7:0]) * 32'h0101_0101;
    else if (nb == 2) exp_wd = 32'(sd[15:0]) * 32'h0001_0001;
    else              exp_wd = sd;
    exp_ws = (nb == 4) ? 4'hF : (nb == 1 ? 4'(1 << o) : 4'(3 << o));

    start = 1'b1; store_memory = st; load_memory = ld; load_memory_size = sz;
    load_memory_sign_extension = sg; address = ad; store_data = sd; rd_in = rd;
    next_cycle();
    scramble_inputs(rnd_start);

    if (mis) begin
      check("mis_req", 32'(mem_req), 0);
      check("mis_done", 32'(done), 1);
      check("mis_fault", 32'(fault), 1);
      check("mis_cause", 32'(fault_cause), 1);
      check("mis_regwe", 32'(reg_we_out), 0);
      check("mis_rd", 32'(rd_out), 32'(rd));
    end else begin
      for (int n = 0; n < ncyc; n++) begin
        check("req", 32'(mem_req), 1);
        check("req_busy", 32'(busy), 1);
        check("req_done", 32'(done), 0);
        check("req_addr", mem_addr, {ad[31:2], 2'b00});
        check("req_we", 32'(mem_we), 32'(is_store));
        if (is_store) begin
          check("req_wdata", mem_wdata, exp_wd);
          check("req_wstrb", 32'(mem_wstrb), 32'(exp_ws));
        end else begin
          check("req_wstrb_rd", 32'(mem_wstrb), 0);
        end
        mem_ready = (n == dly);
        mem_rdata = (n == dly) ? rdat : $urandom;
        if (rnd_start) start = 1'($urandom);
        next_cycle();
        mem_ready = 1'b0;
      end
      check("resp_req", 32'(mem_req), 0);
      check("resp_done", 32'(done), 1);
      check("resp_fault", 32'(fault), 32'(tmo));
      check("resp_cause", 32'(fault_cause), tmo ? 2 : 0);
      check("resp_regwe", 32'(reg_we_out), 32'(!is_store && !tmo));
      check("resp_rd", 32'(rd_out), 32'(rd));
      if (!is_store && !tmo) check("load_data", load_data, ref_load(nb, sg, o, rdat));
    end
    if (rnd_start) start = 1'($urandom);
    next_cycle();
    start = 1'b0;
    check("post_busy", 32'(busy), 0);
    check("post_done", 32'(done), 0);
    check("post_req", 32'(mem_req), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    load_memory = 1'b0; store_memory = 1'b0; load_memory_size = 6'd0;
    load_memory_sign_extension = 1'b0; address = '0; store_data = '0; rd_in = '0;
    next_cycle();
    check("rst_req", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ld", load_data, 0);
    check("rst_misc", {24'd0, mem_we, mem_wstrb, reg_we_out, fault_cause}, 0);
    rst = 1'b0;
    next_cycle();

    // Directed cases.
    do_access(0, 1, 6'd8,  1, 32'h0000_1003, 32'h0,         5'd7,  0, 32'h80FF_FF00, 0);
    do_access(0, 1, 6'd16, 0, 32'h0000_2002, 32'h0,         5'd9,  0, 32'hBEEF_1234, 0);
    do_access(0, 1, 6'd16, 1, 32'h0000_2002, 32'h0,         5'd9,  1, 32'hBEEF_1234, 0);
    do_access(1, 0, 6'd8,  0, 32'h0000_0011, 32'hAABB_CCDD, 5'd3,  3, 32'h0,         0);
    do_access(1, 0, 6'd32, 0, 32'h0000_0006, 32'h1234_5678, 5'd4,  0, 32'h0,         0);
    do_access(1, 1, 6'd16, 0, 32'h0000_3002, 32'h0000_CAFE, 5'd11, 1, 32'h0,         0);
    do_access(0, 1, 6'd32, 0, 32'h0000_4000, 32'h0,         5'd12, 99, 32'h0,        0);

    // Ready pulse while idle is ignored.
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    next_cycle();
    mem_ready = 1'b0;
    check("idle_ready_busy", 32'(busy), 0);
    check("idle_ready_done", 32'(done), 0);

    // Start without load or store is ignored.
    start = 1'b1; load_memory = 1'b0; store_memory = 1'b0;
    next_cycle();
    start = 1'b0;
    check("nop_busy", 32'(busy), 0);
    check("nop_req", 32'(mem_req), 0);

    // Reset in the middle of a bus cycle.
    start = 1'b1; load_memory = 1'b1; store_memory = 1'b0; load_memory_size = 6'd32;
    address = 32'h0000_5000; rd_in = 5'd5;
    next_cycle();
    start = 1'b0;
    check("pre_rst_req", 32'(mem_req), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(mem_req), 0);
    check("rst_mid_busy", 32'(busy), 0);
    #1 rst = 1'b0;
    next_cycle();
    check("rst_mid_done", 32'(done), 0);
    next_cycle();
    check("rst_mid_done2", 32'(done), 0);
    check("rst_mid_busy2", 32'(busy), 0);

    // Randomized accesses with random start noise while busy.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] sz;
      int sel, op;
      logic [31:0] ad;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: sz = 6'd8;
        1: sz = 6'd16;
        2: sz = 6'd32;
        3: sz = 6'd0;
        4: sz = 6'd63;
        default: sz = 6'd24;
      endcase
      op = int'($urandom_range(0, 2));
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      do_access(op != 1, op != 0, sz, 1'($urandom), ad, $urandom, 5'($urandom),
                int'($urandom_range(0, 5)), $urandom, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
- Multi-cycle sequencer for the core's data memory port.
- Accepts one load or store per request, using the decoder's memory controls (load_memory, store_memory, load_memory_size, load_memory_sign_extension) plus the ALU-computed address.
- Drives a single-outstanding req/ready memory bus with byte strobes.
- Returns aligned, extended load data with a register write-enable, and stalls the core via busy while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: max REQ cycles without mem_ready before abort; 0 disables timeout.
- TIMER_WIDTH, 8: width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  request valid, sampled only in IDLE
- load_memory  input  1  request is a load
- store_memory  input  1  request is a store (priority over load if both)
- load_memory_size  input  6  access size 8/16/32; any other value treated as 32
- load_memory_sign_extension  input  1  sign-extend load result
- address  input  32  byte address from ALU
- store_data  input  32  rs2 value
- rd_in  input  5  destination register
- mem_req  output  1  bus request
- mem_we  output  1  1=write
- mem_addr  output  32  word-aligned address {address[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte strobes (0 on reads)
- mem_ready  input  1  bus completion; mem_rdata valid same cycle
- mem_rdata  input  32  read word
- busy  output  1  state != IDLE
- done  output  1  one-cycle completion pulse
- load_data  output  32  extended load result, valid with done
- rd_out  output  5  latched rd_in
- reg_we_out  output  1  with done: 1 only for successful load
- fault  output  1  with done: access failed
- fault_cause  output  2  00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset (async): state IDLE; every output 0; timer 0. Reset mid-access drops mem_req immediately, and no done pulse follows.
- States: IDLE, REQ, RESP.
- IDLE, start=1 and (load_memory|store_memory) at edge: latch all request inputs.
  - Aligned access → REQ.
  - Misaligned access (16-bit with address[0]=1; 32-bit with address[1:0]!=0) → RESP with fault=1, cause=01; no bus cycle.
- IDLE, start=1 with neither load nor store: ignored, stays IDLE.
- start outside IDLE: ignored.
- REQ: mem_req=1, with mem_we/mem_addr/mem_wdata/mem_wstrb stable from latched values until the ready cycle.
  - mem_ready=1 at edge → RESP, capture mem_rdata.
  - Otherwise timer increments.
  - When TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES-1 without ready → RESP with fault=1, cause=10.
- RESP: done=1 for exactly one cycle, then IDLE.
  - load_data, rd_out, reg_we_out, fault, fault_cause are valid only in RESP and 0 otherwise.
  - reg_we_out=0 for stores and for faults.
- Minimum latency: start at edge k, mem_req during cycle k+1, done during cycle k+2. Peak throughput is one access per 3 cycles.
- Store lanes (o = address[1:0]):
  - 8-bit: wdata={4{store_data[7:0]}}, wstrb=4'b0001<<o.
  - 16-bit: wdata={2{store_data[15:0]}}, wstrb=4'b0011<<o.
  - 32-bit: wdata=store_data, wstrb=4'b1111.
- Loads: shifted = mem_rdata >> (8*o).
  - 8-bit: load_data = shifted[7:0], sign- or zero-extended per latched sign flag.
  - 16-bit: load_data = shifted[15:0], sign- or zero-extended per latched sign flag.
  - 32-bit: load_data = the full word.
- mem_ready outside REQ is ignored. Timer clears on entry to REQ.

Test Plan:
- Byte load: address=0x1003, size=8, sign=1, mem_rdata=0x80FF_FF00 with ready on first REQ cycle → mem_addr=0x1000, wstrb=0, done at k+2, load_data=0xFFFF_FF80, reg_we_out=1, rd_out=rd_in.
- Halfword zero-extend load: address=0x2002, size=16, sign=0, rdata=0xBEEF_1234 → load_data=0x0000_BEEF. Same with sign=1 → 0xFFFF_BEEF.
- Store byte: address=0x11, store_data=0xAABB_CCDD, size=8, ready held low 3 cycles → mem_req high 4 cycles with stable wdata=0xDDDD_DDDD, wstrb=4'b0010; done with reg_we_out=0, fault=0.
- Misaligned word store: address=0x6 → no mem_req, done next cycle, fault=1, fault_cause=01.
- Timeout: TIMEOUT_CYCLES=4, ready never asserted → mem_req high exactly 4 cycles, then done with fault=1, cause=10, reg_we_out=0. A later ready pulse is ignored.
- Reset/back-pressure: assert rst during REQ → mem_req and busy low immediately, no done. start pulsed while busy → ignored; exactly one bus transaction per accepted start.
